btn_sw_conditioner: RTL and testbench

//  Input-side counterpart of the board LED driver: conditions raw, asynchronous

---
 rtl/btn_sw_conditioner_if.sv | 40 ++++
 rtl/btn_sw_conditioner.sv | 167 ++++++++++++++++
 tb/tb_btn_sw_conditioner.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/btn_sw_conditioner_if.sv
// Raw pin inputs and conditioned outputs of the button/switch conditioner.
interface btn_sw_conditioner_if #(
  parameter int unsigned N_BTN = 3,
  parameter int unsigned N_SW  = 2
) ();

  logic [N_BTN-1:0] btn_raw;
  logic [N_SW-1:0]  sw_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_repeat;
  logic [N_SW-1:0]  sw_level;

  // Board/stimulus side: drives the pins, observes conditioned results.
  modport master (
    output btn_raw,
    output sw_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long,
    input  btn_repeat,
    input  sw_level
  );

  // Conditioner side.
  modport slave (
    input  btn_raw,
    input  sw_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long,
    output btn_repeat,
    output sw_level
  );

endinterface

// File: rtl/btn_sw_conditioner.sv
// Button/switch input conditioner: synchronise, debounce, and derive
// press/release/long-press/auto-repeat pulses per button.
module btn_sw_conditioner #(
  parameter int unsigned N_BTN           = 3,
  parameter int unsigned N_SW            = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
  parameter int unsigned LONG_CYCLES     = 50_000_000,
  parameter int unsigned REPEAT_CYCLES   = 12_500_000
) (
  input  logic                  clk,
  input  logic                  rst,
  btn_sw_conditioner_if.slave   io
);

  // Buttons occupy the low bits of the combined input vector, switches the high bits.
  localparam int unsigned N_IN   = N_BTN + N_SW;
  localparam int unsigned CNT_W  = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HC_MAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
  localparam int unsigned HC_W   = $clog2(HC_MAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btn_state_e;

  logic [N_IN-1:0] raw_c;
  logic [N_IN-1:0] s1_q;
  logic [N_IN-1:0] s2_q;
  logic [N_IN-1:0] level_c;
  logic [N_IN-1:0] accept_c;

  assign raw_c = {io.sw_raw, io.btn_raw};

  // Two-flop synchroniser for every asynchronous pin.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= raw_c;
      s2_q <= s1_q;
    end
  end

  // Per-input debounce: a change is accepted only after DEBOUNCE_CYCLES
  // consecutive synchronised samples that differ from the held level.
  for (genvar i = 0; i < N_IN; i++) begin : g_db
    logic [CNT_W-1:0] cnt_q;
    logic             lvl_q;
    logic             differ_c;

    assign differ_c    = (s2_q[i] != lvl_q);
    assign accept_c[i] = differ_c && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
    assign level_c[i]  = lvl_q;

    // Debounce counter and accepted level.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        cnt_q <= '0;
        lvl_q <= 1'b0;
      end else if (!differ_c) begin
        cnt_q <= '0;
      end else if (accept_c[i]) begin
        lvl_q <= s2_q[i];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign io.btn_level = level_c[N_BTN-1:0];
  assign io.sw_level  = level_c[N_IN-1:N_BTN];

  // Per-button pulse generation and hold-time FSM. The FSM reacts to the
  // accept event itself, so its state tracks the level register edge-for-edge.
  for (genvar b = 0; b < N_BTN; b++) begin : g_btn
    btn_state_e      state_q;
    btn_state_e      state_d;
    logic [HC_W-1:0] hc_q;
    logic [HC_W-1:0] hc_d;
    logic            rise_c;
    logic            fall_c;
    logic            press_d;
    logic            release_d;
    logic            long_d;
    logic            repeat_d;
    logic            press_q;
    logic            release_q;
    logic            long_q;
    logic            repeat_q;

    assign rise_c = accept_c[b] &&  s2_q[b];
    assign fall_c = accept_c[b] && !s2_q[b];

    // Next-state, hold counter and pulse decode; release beats a coincident limit.
    always_comb begin
      state_d   = state_q;
      hc_d      = hc_q;
      press_d   = rise_c;
      release_d = fall_c;
      long_d    = 1'b0;
      repeat_d  = 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (rise_c) begin
            state_d = ST_HELD;
            hc_d    = HC_W'(1);
          end
        end
        ST_HELD: begin
          if (fall_c) begin
            state_d = ST_IDLE;
            hc_d    = '0;
          end else if (hc_q == HC_W'(LONG_CYCLES)) begin
            long_d  = 1'b1;
            hc_d    = HC_W'(1);
            state_d = ST_REPEAT;
          end else begin
            hc_d = hc_q + HC_W'(1);
          end
        end
        ST_REPEAT: begin
          if (fall_c) begin
            state_d = ST_IDLE;
            hc_d    = '0;
          end else if (hc_q == HC_W'(REPEAT_CYCLES)) begin
            repeat_d = 1'b1;
            hc_d     = HC_W'(1);
          end else begin
            hc_d = hc_q + HC_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          hc_d    = '0;
        end
      endcase
    end

    // State, hold counter and registered one-cycle pulses.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q   <= ST_IDLE;
        hc_q      <= '0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        repeat_q  <= 1'b0;
      end else begin
        state_q   <= state_d;
        hc_q      <= hc_d;
        press_q   <= press_d;
        release_q <= release_d;
        long_q    <= long_d;
        repeat_q  <= repeat_d;
      end
    end

    assign io.btn_press[b]   = press_q;
    assign io.btn_release[b] = release_q;
    assign io.btn_long[b]    = long_q;
    assign io.btn_repeat[b]  = repeat_q;
  end

endmodule

// File: tb/tb_btn_sw_conditioner.sv
// Scoreboard bench for btn_sw_conditioner with small debounce/hold constants.
module tb_btn_sw_conditioner;

  localparam int unsigned N_BTN = 3;
  localparam int unsigned N_SW  = 2;

  typedef struct {
    int          cyc;
    logic [11:0] pulse;  // {press, release, long, repeat}
  } ev_t;

  logic  clk = 1'b0;
  logic  rst = 1'b0;
  int    cyc = 0;
  int    n_total = 0;
  int    n_bad = 0;
  ev_t   sb[$];
  ev_t   ev_m;
  logic [11:0] got_m;
  logic [16:0] all_out;

  btn_sw_conditioner_if #(.N_BTN(N_BTN), .N_SW(N_SW)) io ();

  btn_sw_conditioner #(
    .N_BTN(N_BTN),
    .N_SW(N_SW),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .REPEAT_CYCLES(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io(io.slave)
  );

  always #5 clk = ~clk;

  // Edge counter: value read at a negedge is the number of rising edges so far.
  always @(posedge clk) cyc <= cyc + 1;

  assign all_out = {io.btn_level, io.btn_press, io.btn_release,
                    io.btn_long, io.btn_repeat, io.sw_level};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h (cyc=%0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input logic [2:0] pr, input logic [2:0] rl,
                               input logic [2:0] lg, input logic [2:0] rp);
    ev_t e;
    e.cyc   = c;
    e.pulse = {pr, rl, lg, rp};
    sb.push_back(e);
  endfunction

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: every cycle carrying any pulse must match the next expected event.
  always @(negedge clk) begin
    got_m = {io.btn_press, io.btn_release, io.btn_long, io.btn_repeat};
    if (got_m != 12'd0) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'(got_m), 32'd0);
      end else begin
        ev_m = sb.pop_front();
        check("ev_cyc", cyc, ev_m.cyc);
        check("ev_pulse", 32'(got_m), 32'(ev_m.pulse));
      end
    end
  end

  initial begin
    int c;
    int p;
    int r;

    // 1: buttons already high through reset; accepted by normal debounce afterwards.
    io.btn_raw = 3'b111;
    io.sw_raw  = 2'b00;
    repeat (3) @(negedge clk);
    check("in_reset_out", 32'(all_out), 32'd0);
    c   = cyc;
    rst = 1'b1;
    push(c + 6, 3'b111, 3'b000, 3'b000, 3'b000);
    #1;
    check("reset_exit_out", 32'(all_out), 32'd0);
    wait_until(c + 5);
    check("t1_lvl_before", 32'(io.btn_level), 32'd0);
    wait_until(c + 6);
    check("t1_lvl_after", 32'(io.btn_level), 32'b111);
    io.btn_raw = 3'b000;
    push(c + 12, 3'b000, 3'b111, 3'b000, 3'b000);
    wait_until(c + 13);
    check("t1_lvl_released", 32'(io.btn_level), 32'd0);

    // 2: clean press and release of button 0.
    repeat (4) @(negedge clk);
    c = cyc;
    io.btn_raw[0] = 1'b1;
    push(c + 6, 3'b001, 3'b000, 3'b000, 3'b000);
    wait_until(c + 5);
    check("t2_lvl_before", 32'(io.btn_level), 32'd0);
    wait_until(c + 6);
    check("t2_lvl_after", 32'(io.btn_level), 32'b001);
    wait_until(c + 10);
    io.btn_raw[0] = 1'b0;
    push(c + 16, 3'b000, 3'b001, 3'b000, 3'b000);
    wait_until(c + 17);
    check("t2_lvl_released", 32'(io.btn_level), 32'd0);

    // 3: bouncing button 1; only the final stable high is accepted.
    repeat (4) @(negedge clk);
    c = cyc;
    for (int i = 0; i < 4; i++) begin
      io.btn_raw[1] = (i % 2 == 0);
      @(negedge clk);
    end
    io.btn_raw[1] = 1'b1;
    push(c + 10, 3'b010, 3'b000, 3'b000, 3'b000);
    wait_until(c + 9);
    check("t3_lvl_during_bounce", 32'(io.btn_level), 32'd0);
    wait_until(c + 14);
    io.btn_raw[1] = 1'b0;
    push(c + 20, 3'b000, 3'b010, 3'b000, 3'b000);
    wait_until(c + 21);
    check("t3_lvl_released", 32'(io.btn_level), 32'd0);

    // 4: long hold on button 2; release lands on the repeat limit and wins.
    repeat (4) @(negedge clk);
    c = cyc;
    p = c + 6;
    io.btn_raw[2] = 1'b1;
    push(p,      3'b100, 3'b000, 3'b000, 3'b000);
    push(p + 20, 3'b000, 3'b000, 3'b100, 3'b000);
    push(p + 28, 3'b000, 3'b000, 3'b000, 3'b100);
    push(p + 36, 3'b000, 3'b000, 3'b000, 3'b100);
    push(p + 44, 3'b000, 3'b000, 3'b000, 3'b100);
    push(p + 52, 3'b000, 3'b000, 3'b000, 3'b100);
    push(p + 60, 3'b000, 3'b100, 3'b000, 3'b000);
    wait_until(p + 40);
    check("t4_lvl_held", 32'(io.btn_level), 32'b100);
    wait_until(p + 54);
    io.btn_raw[2] = 1'b0;
    wait_until(p + 61);
    check("t4_lvl_released", 32'(io.btn_level), 32'd0);

    // 5: button 0 level falls exactly when the hold count hits the long limit.
    repeat (4) @(negedge clk);
    c = cyc;
    p = c + 6;
    io.btn_raw[0] = 1'b1;
    push(p,      3'b001, 3'b000, 3'b000, 3'b000);
    push(p + 20, 3'b000, 3'b001, 3'b000, 3'b000);
    wait_until(p + 14);
    io.btn_raw[0] = 1'b0;
    wait_until(p + 25);
    check("t5_lvl_released", 32'(io.btn_level), 32'd0);

    // 6: asynchronous reset in the middle of auto-repeat, then switch debounce.
    repeat (4) @(negedge clk);
    c = cyc;
    p = c + 6;
    io.btn_raw[1] = 1'b1;
    push(p,      3'b010, 3'b000, 3'b000, 3'b000);
    push(p + 20, 3'b000, 3'b000, 3'b010, 3'b000);
    push(p + 28, 3'b000, 3'b000, 3'b000, 3'b010);
    wait_until(p + 30);
    check("t6_lvl_in_repeat", 32'(io.btn_level), 32'b010);
    #2;
    rst        = 1'b0;
    io.sw_raw  = 2'b10;
    io.btn_raw = 3'b000;
    #1;
    check("t6_async_clear", 32'(all_out), 32'd0);
    repeat (2) @(negedge clk);
    r   = cyc;
    rst = 1'b1;
    wait_until(r + 5);
    check("t6_sw_before", 32'(io.sw_level), 32'd0);
    wait_until(r + 6);
    check("t6_sw_after", 32'(io.sw_level), 32'b10);
    check("t6_btn_lvl", 32'(io.btn_level), 32'd0);
    wait_until(r + 30);
    check("sb_empty", sb.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
